// File: rtl/tcp_ack_state_ctrl.sv
// ---------------------------------------------------------------------------
// tcp_ack_state_ctrl
//
// Purpose:
//   Sequencer for the slow-path TCP ACK-state update. It accepts one inbound
//   ACK event and reads that flow's send state from the flow state table. It
//   presents the operands to the external combinational ACK evaluator, then
//   writes the evaluated ACK state back. It also publishes a new TX head
//   pointer when the ACK number moved, and raises a retransmit request when
//   the evaluator asks for one.
//
//   Sequence: IDLE -> RD -> WAIT -> EVAL -> WR -> (RT_WAIT) -> IDLE
//
// Build option:
//   TCP_ACK_CTRL_RT_HOLD_EN
//     Defined   : rt_req_val/rt_req_flowid form a valid/ready handshake. If
//                 rt_req_rdy is low in WR, the FSM parks in RT_WAIT holding
//                 the request. No new event is accepted until it is taken.
//     Undefined : rt_req_val is a one-cycle fire-and-forget pulse in WR.
//                 rt_req_rdy is ignored and RT_WAIT does not exist.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ack_evt_*                  inbound ACK event (val/rdy)
//   state_rd_req_*             state table read strobe + index
//   state_rd_resp_*            read data, fixed 1-cycle latency
//   eval_* (out)               registered operands to the ACK evaluator
//   eval_next_*, eval_set_rt   evaluator results, sampled at the end of EVAL
//   state_wr_*                 state table write-back (1-cycle strobe)
//   head_ptr_wr_*              TX head pointer update (1-cycle strobe)
//   rt_req_*                   retransmit request
//   busy                       high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module tcp_ack_state_ctrl #(
  parameter int FLOWID_W      = 8,
  parameter int ACK_NUM_W     = 32,
  parameter int DUP_CNT_W     = 2,
  parameter int PAYLOAD_LEN_W = 16,
  parameter int TX_PTR_W      = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     ack_evt_val,
  input  logic [FLOWID_W-1:0]      ack_evt_flowid,
  input  logic [ACK_NUM_W-1:0]     ack_evt_ack_num,
  input  logic [PAYLOAD_LEN_W-1:0] ack_evt_payload_len,
  output logic                     ack_evt_rdy,

  output logic                     state_rd_req_val,
  output logic [FLOWID_W-1:0]      state_rd_req_flowid,
  input  logic [ACK_NUM_W-1:0]     state_rd_resp_seq_num,
  input  logic [ACK_NUM_W-1:0]     state_rd_resp_ack_num,
  input  logic [DUP_CNT_W-1:0]     state_rd_resp_dup_cnt,

  output logic [ACK_NUM_W-1:0]     eval_pkt_ack_num,
  output logic [ACK_NUM_W-1:0]     eval_seq_num,
  output logic [ACK_NUM_W-1:0]     eval_ack_num,
  output logic [DUP_CNT_W-1:0]     eval_dup_cnt,
  output logic [PAYLOAD_LEN_W-1:0] eval_payload_len,
  input  logic [ACK_NUM_W-1:0]     eval_next_ack_num,
  input  logic [DUP_CNT_W-1:0]     eval_next_dup_cnt,
  input  logic                     eval_set_rt,
  input  logic [TX_PTR_W:0]        eval_next_head_ptr,

  output logic                     state_wr_val,
  output logic [FLOWID_W-1:0]      state_wr_flowid,
  output logic [ACK_NUM_W-1:0]     state_wr_ack_num,
  output logic [DUP_CNT_W-1:0]     state_wr_dup_cnt,

  output logic                     head_ptr_wr_val,
  output logic [FLOWID_W-1:0]      head_ptr_wr_flowid,
  output logic [TX_PTR_W:0]        head_ptr_wr_ptr,

  output logic                     rt_req_val,
  output logic [FLOWID_W-1:0]      rt_req_flowid,
  input  logic                     rt_req_rdy,

  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_WAIT    = 3'd2,
    S_EVAL    = 3'd3,
    S_WR      = 3'd4
`ifdef TCP_ACK_CTRL_RT_HOLD_EN
    ,
    S_RT_WAIT = 3'd5
`endif
  } state_e;

  state_e state_q, state_d;

  // Event fields captured at accept.
  logic [FLOWID_W-1:0]      flowid_q;
  logic [ACK_NUM_W-1:0]     pkt_ack_q;
  logic [PAYLOAD_LEN_W-1:0] payload_q;

  // Evaluator operands. They are loaded in WAIT and are otherwise untouched,
  // so they are stable through EVAL and hold their values afterwards.
  logic [ACK_NUM_W-1:0]     eval_pkt_ack_q;
  logic [ACK_NUM_W-1:0]     eval_seq_q;
  logic [ACK_NUM_W-1:0]     eval_ack_q;
  logic [DUP_CNT_W-1:0]     eval_dup_q;
  logic [PAYLOAD_LEN_W-1:0] eval_payload_q;

  // Write-port data. Each group is loaded only when its strobe will fire,
  // so the data outputs hold between strobes.
  logic [FLOWID_W-1:0]      wr_flowid_q;
  logic [ACK_NUM_W-1:0]     wr_ack_q;
  logic [DUP_CNT_W-1:0]     wr_dup_q;
  logic                     head_chg_q;
  logic [FLOWID_W-1:0]      hp_flowid_q;
  logic [TX_PTR_W:0]        hp_ptr_q;
  logic                     set_rt_q;
  logic [FLOWID_W-1:0]      rt_flowid_q;

  // The head pointer is republished only when the ACK number actually moved.
  // This is a plain equality test; all sequence arithmetic lives in the
  // evaluator.
  logic head_chg;
  assign head_chg = (eval_next_ack_num != eval_ack_q);

  assign state_rd_req_flowid = flowid_q;
  assign eval_pkt_ack_num    = eval_pkt_ack_q;
  assign eval_seq_num        = eval_seq_q;
  assign eval_ack_num        = eval_ack_q;
  assign eval_dup_cnt        = eval_dup_q;
  assign eval_payload_len    = eval_payload_q;
  assign state_wr_flowid     = wr_flowid_q;
  assign state_wr_ack_num    = wr_ack_q;
  assign state_wr_dup_cnt    = wr_dup_q;
  assign head_ptr_wr_flowid  = hp_flowid_q;
  assign head_ptr_wr_ptr     = hp_ptr_q;
  assign rt_req_flowid       = rt_flowid_q;

`ifndef TCP_ACK_CTRL_RT_HOLD_EN
  // Fire-and-forget retransmit: the ready input has no effect.
  logic unused_rt_req_rdy;
  assign unused_rt_req_rdy = rt_req_rdy;
`endif

  // Next-state and strobe decode.
  always_comb begin
    state_d          = state_q;
    ack_evt_rdy      = 1'b0;
    busy             = 1'b1;
    state_rd_req_val = 1'b0;
    state_wr_val     = 1'b0;
    head_ptr_wr_val  = 1'b0;
    rt_req_val       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ack_evt_rdy = 1'b1;
        busy        = 1'b0;
        if (ack_evt_val) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_rd_req_val = 1'b1;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        state_d = S_WR;
      end
      S_WR: begin
        state_wr_val    = 1'b1;
        head_ptr_wr_val = head_chg_q;
        rt_req_val      = set_rt_q;
        state_d         = S_IDLE;
`ifdef TCP_ACK_CTRL_RT_HOLD_EN
        if (set_rt_q && !rt_req_rdy) begin
          state_d = S_RT_WAIT;
        end
`endif
      end
`ifdef TCP_ACK_CTRL_RT_HOLD_EN
      S_RT_WAIT: begin
        // Only the retransmit request is held; the writes already happened.
        rt_req_val = 1'b1;
        if (rt_req_rdy) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      flowid_q       <= '0;
      pkt_ack_q      <= '0;
      payload_q      <= '0;
      eval_pkt_ack_q <= '0;
      eval_seq_q     <= '0;
      eval_ack_q     <= '0;
      eval_dup_q     <= '0;
      eval_payload_q <= '0;
      wr_flowid_q    <= '0;
      wr_ack_q       <= '0;
      wr_dup_q       <= '0;
      head_chg_q     <= 1'b0;
      hp_flowid_q    <= '0;
      hp_ptr_q       <= '0;
      set_rt_q       <= 1'b0;
      rt_flowid_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (ack_evt_val) begin
            flowid_q  <= ack_evt_flowid;
            pkt_ack_q <= ack_evt_ack_num;
            payload_q <= ack_evt_payload_len;
          end
        end
        S_WAIT: begin
          eval_pkt_ack_q <= pkt_ack_q;
          eval_payload_q <= payload_q;
          eval_seq_q     <= state_rd_resp_seq_num;
          eval_ack_q     <= state_rd_resp_ack_num;
          eval_dup_q     <= state_rd_resp_dup_cnt;
        end
        S_EVAL: begin
          wr_flowid_q <= flowid_q;
          wr_ack_q    <= eval_next_ack_num;
          wr_dup_q    <= eval_next_dup_cnt;
          head_chg_q  <= head_chg;
          set_rt_q    <= eval_set_rt;
          if (head_chg) begin
            hp_flowid_q <= flowid_q;
            hp_ptr_q    <= eval_next_head_ptr;
          end
          if (eval_set_rt) begin
            rt_flowid_q <= flowid_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
